// File: rtl/pipe_stage_buf.sv
// Pipeline-stage register with valid/ready handshake, optional 2-entry skid,
// flush and exception redirect. Payload, PC, branch-delay flag and ExcCode travel together.
module pipe_stage_buf #(
    parameter int unsigned DATA_W   = 160,
    parameter int unsigned CODE_W   = 5,
    parameter logic [31:0] RESET_PC = 32'h3000,
    parameter logic [31:0] EXC_PC   = 32'h4180,
    parameter int unsigned SKID     = 1
) (
    input  logic              clk_i,
    input  logic              reset_ni,
    input  logic              req_i,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [31:0]       in_pc_i,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic              in_bd_i,
    input  logic [CODE_W-1:0] in_exc_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [31:0]       out_pc_o,
    output logic [DATA_W-1:0] out_data_o,
    output logic              out_bd_o,
    output logic [CODE_W-1:0] out_exc_o
);

    typedef enum logic [1:0] {StEmpty, StFull, StSkid2} state_e;

    state_e              state_q, state_d;
    logic [31:0]         main_pc_q, main_pc_d;
    logic [DATA_W-1:0]   main_data_q, main_data_d;
    logic                main_bd_q, main_bd_d;
    logic [CODE_W-1:0]   main_exc_q, main_exc_d;
    logic [31:0]         skid_pc_q, skid_pc_d;
    logic [DATA_W-1:0]   skid_data_q, skid_data_d;
    logic                skid_bd_q, skid_bd_d;
    logic [CODE_W-1:0]   skid_exc_q, skid_exc_d;

    logic accept;
    logic consume;

    assign out_valid_o = (state_q != StEmpty);
    assign out_pc_o    = main_pc_q;
    assign out_data_o  = main_data_q;
    assign out_bd_o    = main_bd_q;
    assign out_exc_o   = main_exc_q;

    assign accept  = in_valid_i & in_ready_o;
    assign consume = out_valid_o & out_ready_i;

    always_comb begin
        state_d     = state_q;
        main_pc_d   = main_pc_q;
        main_data_d = main_data_q;
        main_bd_d   = main_bd_q;
        main_exc_d  = main_exc_q;
        skid_pc_d   = skid_pc_q;
        skid_data_d = skid_data_q;
        skid_bd_d   = skid_bd_q;
        skid_exc_d  = skid_exc_q;

        if (req_i || flush_i) begin
            // Any bundle offered this cycle is dropped along with the held ones.
            state_d     = StEmpty;
            main_data_d = '0;
            main_bd_d   = 1'b0;
            main_exc_d  = '0;
            skid_pc_d   = '0;
            skid_data_d = '0;
            skid_bd_d   = 1'b0;
            skid_exc_d  = '0;
            if (req_i) begin
                main_pc_d = EXC_PC;
            end
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (accept) begin
                        state_d     = StFull;
                        main_pc_d   = in_pc_i;
                        main_data_d = in_data_i;
                        main_bd_d   = in_bd_i;
                        main_exc_d  = in_exc_i;
                    end
                end
                StFull: begin
                    if (accept && consume) begin
                        main_pc_d   = in_pc_i;
                        main_data_d = in_data_i;
                        main_bd_d   = in_bd_i;
                        main_exc_d  = in_exc_i;
                    end else if (accept && (SKID != 0)) begin
                        state_d     = StSkid2;
                        skid_pc_d   = in_pc_i;
                        skid_data_d = in_data_i;
                        skid_bd_d   = in_bd_i;
                        skid_exc_d  = in_exc_i;
                    end else if (consume) begin
                        // Bubble keeps reporting the last valid PC.
                        state_d     = StEmpty;
                        main_data_d = '0;
                        main_bd_d   = 1'b0;
                        main_exc_d  = '0;
                    end
                end
                StSkid2: begin
                    if (consume) begin
                        state_d     = StFull;
                        main_pc_d   = skid_pc_q;
                        main_data_d = skid_data_q;
                        main_bd_d   = skid_bd_q;
                        main_exc_d  = skid_exc_q;
                        skid_pc_d   = '0;
                        skid_data_d = '0;
                        skid_bd_d   = 1'b0;
                        skid_exc_d  = '0;
                    end
                end
                default: state_d = StEmpty;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state_q     <= StEmpty;
            main_pc_q   <= RESET_PC;
            main_data_q <= '0;
            main_bd_q   <= 1'b0;
            main_exc_q  <= '0;
            skid_pc_q   <= '0;
            skid_data_q <= '0;
            skid_bd_q   <= 1'b0;
            skid_exc_q  <= '0;
        end else begin
            state_q     <= state_d;
            main_pc_q   <= main_pc_d;
            main_data_q <= main_data_d;
            main_bd_q   <= main_bd_d;
            main_exc_q  <= main_exc_d;
            skid_pc_q   <= skid_pc_d;
            skid_data_q <= skid_data_d;
            skid_bd_q   <= skid_bd_d;
            skid_exc_q  <= skid_exc_d;
        end
    end

    if (SKID != 0) begin : g_skid
        // Registered ready breaks the combinational path from out_ready.
        logic in_ready_q;
        always_ff @(posedge clk_i) begin
            if (!reset_ni) begin
                in_ready_q <= 1'b1;
            end else begin
                in_ready_q <= (state_d != StSkid2);
            end
        end
        assign in_ready_o = in_ready_q;
    end else begin : g_single
        assign in_ready_o = ~out_valid_o | out_ready_i;
    end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Self-checking bench: SKID=1 and SKID=0 instances share stimulus, each checked
// every cycle against a queue-based model, plus directed literal checks.
module tb_pipe_stage_buf;

    localparam int unsigned DW = 160;
    localparam int unsigned CW = 5;
    localparam logic [31:0] RPC = 32'h3000;
    localparam logic [31:0] EPC = 32'h4180;

    typedef struct packed {
        logic [31:0]   pc;
        logic [DW-1:0] data;
        logic          bd;
        logic [CW-1:0] exc;
    } bundle_t;

    logic clk = 1'b0;
    logic reset_n, req, flush, in_valid, out_ready, in_bd;
    logic [31:0] in_pc;
    logic [DW-1:0] in_data;
    logic [CW-1:0] in_exc;

    logic rdy1, val1, bd1, rdy0, val0, bd0;
    logic [31:0] pc1, pc0;
    logic [DW-1:0] data1, data0;
    logic [CW-1:0] exc1, exc0;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    bundle_t q1[$];
    bundle_t q0[$];
    logic [31:0] mpc1, mpc0;

    always #5 clk = ~clk;

    pipe_stage_buf #(.DATA_W(DW), .CODE_W(CW), .RESET_PC(RPC), .EXC_PC(EPC), .SKID(1)) dut1 (
        .clk_i(clk), .reset_ni(reset_n), .req_i(req), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(rdy1), .in_pc_i(in_pc), .in_data_i(in_data),
        .in_bd_i(in_bd), .in_exc_i(in_exc), .out_valid_o(val1), .out_ready_i(out_ready),
        .out_pc_o(pc1), .out_data_o(data1), .out_bd_o(bd1), .out_exc_o(exc1)
    );

    pipe_stage_buf #(.DATA_W(DW), .CODE_W(CW), .RESET_PC(RPC), .EXC_PC(EPC), .SKID(0)) dut0 (
        .clk_i(clk), .reset_ni(reset_n), .req_i(req), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(rdy0), .in_pc_i(in_pc), .in_data_i(in_data),
        .in_bd_i(in_bd), .in_exc_i(in_exc), .out_valid_o(val0), .out_ready_i(out_ready),
        .out_pc_o(pc0), .out_data_o(data0), .out_bd_o(bd0), .out_exc_o(exc0)
    );

    task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a FIFO of held bundles (capacity 2 or 1) plus the last reported PC.
    always @(posedge clk) begin
        bundle_t b;
        bit acc1, acc0, con1, con0;
        b = '{pc: in_pc, data: in_data, bd: in_bd, exc: in_exc};
        acc1 = in_valid && (q1.size() < 2);
        acc0 = in_valid && (q0.size() == 0 || out_ready);
        con1 = out_ready && (q1.size() > 0);
        con0 = out_ready && (q0.size() > 0);
        if (!reset_n) begin
            q1.delete(); q0.delete(); mpc1 = RPC; mpc0 = RPC;
        end else if (req) begin
            q1.delete(); q0.delete(); mpc1 = EPC; mpc0 = EPC;
        end else if (flush) begin
            q1.delete(); q0.delete();
        end else begin
            if (con1) void'(q1.pop_front());
            if (acc1) q1.push_back(b);
            if (con0) void'(q0.pop_front());
            if (acc0) q0.push_back(b);
        end
        if (q1.size() > 0) mpc1 = q1[0].pc;
        if (q0.size() > 0) mpc0 = q0[0].pc;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("s1_valid", 192'(val1), 192'(q1.size() > 0));
            chk("s1_ready", 192'(rdy1), 192'(q1.size() < 2));
            chk("s1_pc", 192'(pc1), 192'(mpc1));
            chk("s1_data", 192'(data1), (q1.size() > 0) ? 192'(q1[0].data) : 192'(0));
            chk("s1_bd", 192'(bd1), (q1.size() > 0) ? 192'(q1[0].bd) : 192'(0));
            chk("s1_exc", 192'(exc1), (q1.size() > 0) ? 192'(q1[0].exc) : 192'(0));
            chk("s0_valid", 192'(val0), 192'(q0.size() > 0));
            chk("s0_ready", 192'(rdy0), 192'(q0.size() == 0 || out_ready));
            chk("s0_pc", 192'(pc0), 192'(mpc0));
            chk("s0_data", 192'(data0), (q0.size() > 0) ? 192'(q0[0].data) : 192'(0));
            chk("s0_bd", 192'(bd0), (q0.size() > 0) ? 192'(q0[0].bd) : 192'(0));
            chk("s0_exc", 192'(exc0), (q0.size() > 0) ? 192'(q0[0].exc) : 192'(0));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] pc);
        in_valid = 1'b1;
        in_pc    = pc;
        in_data  = {$urandom, $urandom, $urandom, $urandom, $urandom};
        in_bd    = 1'($urandom);
        in_exc   = CW'($urandom_range(1, 31));
    endtask

    initial begin
        reset_n = 1'b0; req = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_pc = '0; in_data = '0; in_bd = 1'b0; in_exc = '0;
        tick();
        chk_en = 1'b1;
        tick();
        chk("rst_valid", 192'(val1), 192'(0));
        chk("rst_pc", 192'(pc1), 192'(32'h3000));
        chk("rst_ready", 192'(rdy1), 192'(1));
        chk("rst_data", 192'(data1), 192'(0));
        reset_n = 1'b1;

        // Streaming with downstream always ready.
        out_ready = 1'b1;
        offer(32'h3000); tick();
        chk("str_pc0", 192'(pc1), 192'(32'h3000));
        offer(32'h3004); tick();
        chk("str_pc1", 192'(pc1), 192'(32'h3004));
        offer(32'h3008); tick();
        chk("str_pc2", 192'(pc1), 192'(32'h3008));
        chk("str_ready", 192'(rdy1), 192'(1));
        in_valid = 1'b0; tick();
        chk("bubble_pc", 192'(pc1), 192'(32'h3008));
        chk("bubble_data", 192'(data1), 192'(0));

        // Skid fill and ordered drain.
        out_ready = 1'b0;
        offer(32'h3000); tick();
        offer(32'h3004); tick();
        chk("skid2_ready", 192'(rdy1), 192'(0));
        chk("skid2_pc", 192'(pc1), 192'(32'h3000));
        offer(32'h3008); tick();
        chk("skid2_hold", 192'(pc1), 192'(32'h3000));
        out_ready = 1'b1; tick();
        chk("drain1", 192'(pc1), 192'(32'h3004));
        tick();
        chk("drain2", 192'(pc1), 192'(32'h3008));
        in_valid = 1'b0; tick();
        chk("drain_empty", 192'(val1), 192'(0));

        // Exception request while both entries are held.
        out_ready = 1'b0;
        offer(32'h3000); tick();
        offer(32'h3004); tick();
        req = 1'b1; offer(32'h300c); tick();
        chk("req_valid", 192'(val1), 192'(0));
        chk("req_pc", 192'(pc1), 192'(32'h4180));
        chk("req_exc", 192'(exc1), 192'(0));
        chk("req_ready", 192'(rdy1), 192'(1));
        req = 1'b0; in_valid = 1'b0; tick();
        chk("req_lost", 192'(val1), 192'(0));

        // Flush holds PC; reset beats req.
        out_ready = 1'b1;
        offer(32'h3010); tick();
        in_valid = 1'b0; flush = 1'b1; tick();
        chk("flush_valid", 192'(val1), 192'(0));
        chk("flush_pc", 192'(pc1), 192'(32'h3010));
        chk("flush_data", 192'(data1), 192'(0));
        flush = 1'b0; reset_n = 1'b0; req = 1'b1; tick();
        chk("rst_over_req", 192'(pc1), 192'(32'h3000));
        reset_n = 1'b1; req = 1'b0;

        // Single-entry combinational ready.
        out_ready = 1'b0;
        offer(32'h3020); tick();
        chk("s0_full_valid", 192'(val0), 192'(1));
        chk("s0_full_ready", 192'(rdy0), 192'(0));
        out_ready = 1'b1; offer(32'h3024); #1;
        chk("s0_comb_ready", 192'(rdy0), 192'(1));
        tick();
        chk("s0_reload_pc", 192'(pc0), 192'(32'h3024));
        in_valid = 1'b0; tick();

        // Randomized traffic with occasional redirects.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 2) != 0) offer(32'($urandom) & 32'hFFFF_FFFC);
            else in_valid = 1'b0;
            out_ready = ($urandom_range(0, 3) != 0);
            req       = ($urandom_range(0, 39) == 0);
            flush     = ($urandom_range(0, 39) == 0);
            reset_n   = ($urandom_range(0, 99) != 0);
            tick();
        end
        reset_n = 1'b1; req = 1'b0; flush = 1'b0; in_valid = 1'b0;
        tick();
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
